// File: rtl/axi_mem_port_arbiter.sv
// Round-robin arbiter with bounded burst-hold that shares one single-port SRAM between a write port and a read port.
// Define AXI_MEM_ARB_STATS_EN to add grant/conflict statistics counters and their ports.
module axi_mem_port_arbiter #(
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int DATA_WIDTH     = 64,
  parameter int BE_WIDTH       = DATA_WIDTH / 8,
  parameter int MAX_HOLD       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      p0_valid_i,
  input  logic                      p0_wen_i,
  input  logic [MEM_ADDR_WIDTH-1:0] p0_addr_i,
  input  logic [DATA_WIDTH-1:0]     p0_wdata_i,
  input  logic [BE_WIDTH-1:0]       p0_be_i,
  input  logic                      p1_valid_i,
  input  logic                      p1_wen_i,
  input  logic [MEM_ADDR_WIDTH-1:0] p1_addr_i,
  input  logic [DATA_WIDTH-1:0]     p1_wdata_i,
  input  logic [BE_WIDTH-1:0]       p1_be_i,
  output logic                      p0_grant_o,
  output logic                      p1_grant_o,
  output logic                      p0_rvalid_o,
  output logic                      p1_rvalid_o,
  output logic [DATA_WIDTH-1:0]     p0_rdata_o,
  output logic [DATA_WIDTH-1:0]     p1_rdata_o,
  output logic                      MEM_CEN_o,
  output logic                      MEM_WEN_o,
  output logic [MEM_ADDR_WIDTH-1:0] MEM_A_o,
  output logic [DATA_WIDTH-1:0]     MEM_D_o,
  output logic [BE_WIDTH-1:0]       MEM_BE_o,
  input  logic [DATA_WIDTH-1:0]     MEM_Q_i
`ifdef AXI_MEM_ARB_STATS_EN
  ,
  input  logic                      stat_clr_i,
  output logic [31:0]               stat_p0_gnt_o,
  output logic [31:0]               stat_p1_gnt_o,
  output logic [31:0]               stat_conflict_o
`endif
);

  typedef enum logic {
    PRIO_P0 = 1'b0,
    PRIO_P1 = 1'b1
  } prio_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  prio_t      prio;
  logic [7:0] hold_cnt;
  logic [1:0] rd_pend;

  logic  gnt0;
  logic  gnt1;
  logic  any_gnt;
  logic  other_valid;
  logic  both_valid;
  prio_t gnt_port;

  assign both_valid = p0_valid_i & p1_valid_i;

  // Once the priority holder has used up its hold budget, the waiting port wins the conflict.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (both_valid) begin
        if (hold_cnt < HOLD_LIMIT) begin
          gnt0 = (prio == PRIO_P0);
          gnt1 = (prio == PRIO_P1);
        end else begin
          gnt0 = (prio == PRIO_P1);
          gnt1 = (prio == PRIO_P0);
        end
      end else begin
        gnt0 = p0_valid_i;
        gnt1 = p1_valid_i;
      end
    end
  end

  assign any_gnt     = gnt0 | gnt1;
  assign gnt_port    = gnt1 ? PRIO_P1 : PRIO_P0;
  assign other_valid = gnt1 ? p0_valid_i : p1_valid_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio     <= PRIO_P0;
      hold_cnt <= 8'd0;
      rd_pend  <= 2'b00;
    end else begin
      rd_pend <= {gnt1 & p1_wen_i, gnt0 & p0_wen_i};
      if (any_gnt) begin
        if (gnt_port != prio) begin
          prio     <= gnt_port;
          hold_cnt <= other_valid ? 8'd1 : 8'd0;
        end else if (!other_valid) begin
          hold_cnt <= 8'd0;
        end else if (hold_cnt < HOLD_LIMIT) begin
          hold_cnt <= hold_cnt + 8'd1;
        end
      end
    end
  end

  assign p0_grant_o = gnt0;
  assign p1_grant_o = gnt1;

  // SRAM pins idle at a deselected, all-zero pattern when nobody owns the macro.
  always_comb begin
    MEM_CEN_o = 1'b1;
    MEM_WEN_o = 1'b1;
    MEM_A_o   = '0;
    MEM_D_o   = '0;
    MEM_BE_o  = '0;
    if (gnt0) begin
      MEM_CEN_o = 1'b0;
      MEM_WEN_o = p0_wen_i;
      MEM_A_o   = p0_addr_i;
      MEM_D_o   = p0_wdata_i;
      MEM_BE_o  = p0_be_i;
    end else if (gnt1) begin
      MEM_CEN_o = 1'b0;
      MEM_WEN_o = p1_wen_i;
      MEM_A_o   = p1_addr_i;
      MEM_D_o   = p1_wdata_i;
      MEM_BE_o  = p1_be_i;
    end
  end

  // A read that was pending when reset arrives must not leak out during the reset cycle.
  assign p0_rvalid_o = rd_pend[0] & ~rst;
  assign p1_rvalid_o = rd_pend[1] & ~rst;
  assign p0_rdata_o  = p0_rvalid_o ? MEM_Q_i : '0;
  assign p1_rdata_o  = p1_rvalid_o ? MEM_Q_i : '0;

`ifdef AXI_MEM_ARB_STATS_EN
  logic [31:0] p0_gnt_cnt;
  logic [31:0] p1_gnt_cnt;
  logic [31:0] conflict_cnt;

  always_ff @(posedge clk) begin
    if (rst || stat_clr_i) begin
      p0_gnt_cnt   <= 32'd0;
      p1_gnt_cnt   <= 32'd0;
      conflict_cnt <= 32'd0;
    end else begin
      if (gnt0) p0_gnt_cnt <= p0_gnt_cnt + 32'd1;
      if (gnt1) p1_gnt_cnt <= p1_gnt_cnt + 32'd1;
      if (both_valid) conflict_cnt <= conflict_cnt + 32'd1;
    end
  end

  assign stat_p0_gnt_o   = p0_gnt_cnt;
  assign stat_p1_gnt_o   = p1_gnt_cnt;
  assign stat_conflict_o = conflict_cnt;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: doc/axi_mem_port_arbiter.md
Name: axi_mem_port_arbiter

Overview:
- Shares one single-port SRAM macro (CEN/WEN/A/D/BE/Q, 1-cycle registered read) between two requesters of the dual-port AXI memory interface.
- Port 0 is the write-only controller and port 1 is the read-only controller; each uses the same valid/grant memory handshake.
- Arbitration is round-robin with a bounded burst-hold, so a streaming burst keeps the macro for up to MAX_HOLD beats before the other side is served.
- Read data is routed back to the owning port one cycle after the granted access.

Parameters:
- MEM_ADDR_WIDTH, 16, SRAM word address width.
- DATA_WIDTH, 64, SRAM data width.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- MAX_HOLD, 8, max consecutive grants to one port while the other is requesting (legal range 1..255).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- p0_valid_i / p1_valid_i  in  1  access request, port 0 / port 1.
- p0_wen_i / p1_wen_i  in  1  0 = write, 1 = read (SRAM polarity).
- p0_addr_i / p1_addr_i  in  MEM_ADDR_WIDTH  word address.
- p0_wdata_i / p1_wdata_i  in  DATA_WIDTH  write data.
- p0_be_i / p1_be_i  in  BE_WIDTH  byte enables.
- p0_grant_o / p1_grant_o  out  1  access accepted this cycle.
- p0_rvalid_o / p1_rvalid_o  out  1  read data valid, port 0 / port 1.
- p0_rdata_o / p1_rdata_o  out  DATA_WIDTH  read data.
- MEM_CEN_o  out  1  chip enable, active-low.
- MEM_WEN_o  out  1  write enable, active-low.
- MEM_A_o  out  MEM_ADDR_WIDTH  SRAM address.
- MEM_D_o  out  DATA_WIDTH  SRAM write data.
- MEM_BE_o  out  BE_WIDTH  SRAM byte enables.
- MEM_Q_i  in  DATA_WIDTH  SRAM read data, valid one cycle after a read access.

Behaviour:
- Grant is combinational from valid and state, issued in the same cycle; at most one grant per cycle.
- Grant is never asserted without the corresponding valid.
- A requester holds valid and all its inputs stable until granted.
- SRAM side:
  - With a grant, MEM_CEN_o=0 and MEM_WEN_o/A/D/BE are muxed from the granted port.
  - With no grant, MEM_CEN_o=1, MEM_WEN_o=1 and A/D/BE=0.
- State registers:
  - prio (1 bit): port that currently holds priority.
  - hold_cnt (8 bits): consecutive grants to prio while the other port was requesting.
  - rd_pend[1:0]: read-return tracking.
- Grant rules:
  - Only one port valid: grant that port.
  - Both valid and hold_cnt < MAX_HOLD: grant prio.
  - Both valid and hold_cnt == MAX_HOLD: grant ~prio.
- State updates on a grant to port g:
  - If g != prio: prio <= g and hold_cnt <= (other port valid ? 1 : 0).
  - If g == prio: hold_cnt <= other valid ? hold_cnt+1 : 0, saturating at MAX_HOLD.
  - No grant: prio and hold_cnt hold.
- Read return:
  - A granted read (wen=1) on port g sets rd_pend[g] <= 1 for exactly one cycle.
  - pg_rvalid_o = rd_pend[g] and pg_rdata_o = MEM_Q_i.
  - Data of a port with rvalid=0 is don't-care and is driven 0.
  - Granted writes never produce rvalid.
- Back-to-back reads, including an alternating-port sequence, give one rvalid per read with 1-cycle latency and no gaps.
- Reset (synchronous): prio=0, hold_cnt=0, rd_pend=0.
  - All grant and rvalid outputs are 0 during the reset cycle, regardless of valid.
  - MEM_CEN_o=1 during reset.
  - A read granted in the cycle before reset produces no rvalid after reset.

Optional Feature:
- AXI_MEM_ARB_STATS_EN: when defined, adds the following ports.
  - stat_clr_i  in  1  synchronous clear of all three counters.
  - stat_p0_gnt_o  out  32  port 0 grants.
  - stat_p1_gnt_o  out  32  port 1 grants.
  - stat_conflict_o  out  32  cycles with both valid.
  - All three are wrapping 32-bit counters.
  - Cleared by rst or stat_clr_i; clear wins over a simultaneous increment.
- When undefined: these ports and counters do not exist, and arbitration behaviour is identical.

Test Plan:
- Port 0 only, 5 writes to addr 0x10..0x14 with data 0xA0..0xA4 -> p0_grant=1 each cycle; SRAM sees CEN=0, WEN=0; words stored.
- Port 1 reads 0x10..0x12 back-to-back -> p1_rvalid high for 3 consecutive cycles, starting 1 cycle after the first grant; data 0xA0, 0xA1, 0xA2; p0_rvalid stays 0.
- Both ports continuously valid, MAX_HOLD=8, after reset -> grant pattern 8×p0, 8×p1, 8×p0, …; never 9 consecutive grants to one port.
- Port 0 streams 3 beats with port 1 idle, then port 1 asserts valid at cycle 4 -> p0 keeps the grant (hold_cnt 1..) until MAX_HOLD, then p1 is granted.
- Port 1 read granted, rst asserted in the next cycle -> p1_rvalid=0 in that cycle and all following cycles; after rst release prio=0 and both-valid grants p0 first.
- With AXI_MEM_ARB_STATS_EN: 20 cycles of both valid -> stat_conflict_o=20 and stat_p0_gnt_o + stat_p1_gnt_o = 20; stat_clr_i pulse -> all counters 0 the next cycle.
